// File: rtl/vischain_accum.sv
// End-of-chain visibility integrator: sums per-unit re/im words over COUNT frames,
// then drains a snapshot of the sums as (re, im) pairs over valid/ready.
module vischain_accum #(
    parameter int LENGTH = 3,
    parameter int WIDTH  = 7,
    parameter int COUNT  = 4,
    parameter int ACCUM  = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic             m_last_o,
    output logic [ACCUM-1:0] m_re_o,
    output logic [ACCUM-1:0] m_im_o,
    output logic             overflow_o
);

    localparam int WORDS = 2 * LENGTH;
    localparam int WW    = (WORDS > 2) ? $clog2(WORDS) : 1;
    localparam int FW    = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam int IW    = (LENGTH > 1) ? $clog2(LENGTH) : 1;

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                  state_q;
    logic [WW-1:0]           word_q;
    logic [WW-1:0]           unit_w;
    logic [FW-1:0]           frame_q;
    logic [IW-1:0]           idx_q;
    logic [IW-1:0]           idx_nx;
    logic signed [ACCUM-1:0] acc_re_q  [LENGTH];
    logic signed [ACCUM-1:0] acc_im_q  [LENGTH];
    logic signed [ACCUM-1:0] acc_re_d  [LENGTH];
    logic signed [ACCUM-1:0] acc_im_d  [LENGTH];
    logic signed [ACCUM-1:0] snap_re_q [LENGTH];
    logic signed [ACCUM-1:0] snap_im_q [LENGTH];
    logic signed [WIDTH-1:0] data_s;
    logic signed [ACCUM-1:0] data_ext;
    logic                    last_word;
    logic                    last_frame;
    logic                    trigger;
    logic                    transfer;
    logic                    valid_q;
    logic                    last_q;
    logic [ACCUM-1:0]        re_q;
    logic [ACCUM-1:0]        im_q;
    logic                    ovf_q;

    assign data_s     = data_i;
    assign data_ext   = ACCUM'(data_s);
    assign unit_w     = word_q >> 1;
    assign last_word  = (word_q == WW'(WORDS - 1));
    assign last_frame = (frame_q == FW'(COUNT - 1));
    assign trigger    = valid_i & last_word & last_frame;
    assign transfer   = valid_q & m_ready_i;
    assign idx_nx     = idx_q + IW'(1);

    // Sums including the word accepted this cycle; the snapshot captures these directly.
    always_comb begin
        for (int u = 0; u < LENGTH; u++) begin
            acc_re_d[u] = acc_re_q[u];
            acc_im_d[u] = acc_im_q[u];
            if (valid_i && unit_w == WW'(u)) begin
                if (word_q[0])
                    acc_im_d[u] = acc_im_q[u] + data_ext;
                else
                    acc_re_d[u] = acc_re_q[u] + data_ext;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            frame_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
            ovf_q   <= 1'b0;
            for (int u = 0; u < LENGTH; u++) begin
                acc_re_q[u]  <= '0;
                acc_im_q[u]  <= '0;
                snap_re_q[u] <= '0;
                snap_im_q[u] <= '0;
            end
        end else begin
            if (valid_i) begin
                word_q <= last_word ? '0 : word_q + WW'(1);
                if (last_word)
                    frame_q <= last_frame ? '0 : frame_q + FW'(1);
            end
            for (int u = 0; u < LENGTH; u++) begin
                acc_re_q[u] <= trigger ? '0 : acc_re_d[u];
                acc_im_q[u] <= trigger ? '0 : acc_im_d[u];
            end
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        for (int u = 0; u < LENGTH; u++) begin
                            snap_re_q[u] <= acc_re_d[u];
                            snap_im_q[u] <= acc_im_d[u];
                        end
                        state_q <= DRAIN;
                        idx_q   <= '0;
                        valid_q <= 1'b1;
                        last_q  <= (LENGTH == 1);
                        re_q    <= acc_re_d[0];
                        im_q    <= acc_im_d[0];
                    end
                end
                DRAIN: begin
                    // A snapshot arriving while draining is dropped; integration still restarts.
                    if (trigger)
                        ovf_q <= 1'b1;
                    if (transfer) begin
                        if (last_q) begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                        end else begin
                            idx_q  <= idx_nx;
                            re_q   <= snap_re_q[idx_nx];
                            im_q   <= snap_im_q[idx_nx];
                            last_q <= (idx_nx == IW'(LENGTH - 1));
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_valid_o  = valid_q;
    assign m_last_o   = last_q;
    assign m_re_o     = re_q;
    assign m_im_o     = im_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_vischain_accum.sv
// Directed bench for vischain_accum: default build, an 8-bit accumulator build
// and a single-frame (COUNT=1) build share one clock, reset and data bus.
module tb_vischain_accum;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        valid_s;
    int          vsel;
    logic [6:0]  data;
    logic        ready;
    logic        va, vb, vc;
    logic        mv  [3];
    logic        ml  [3];
    logic        ovf [3];
    logic [15:0] mre [3];
    logic [15:0] mim [3];
    logic [15:0] a_re, a_im, c_re, c_im;
    logic [7:0]  b_re, b_im;
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    assign va = valid_s && (vsel == 0);
    assign vb = valid_s && (vsel == 1);
    assign vc = valid_s && (vsel == 2);
    assign mre[0] = a_re;
    assign mim[0] = a_im;
    assign mre[1] = {8'h00, b_re};
    assign mim[1] = {8'h00, b_im};
    assign mre[2] = c_re;
    assign mim[2] = c_im;

    vischain_accum #(.LENGTH(3), .WIDTH(7), .COUNT(4), .ACCUM(16)) dut_a (
        .clock(clock), .reset_n(reset_n), .valid_i(va), .data_i(data),
        .m_valid_o(mv[0]), .m_ready_i(ready), .m_last_o(ml[0]),
        .m_re_o(a_re), .m_im_o(a_im), .overflow_o(ovf[0]));

    vischain_accum #(.LENGTH(3), .WIDTH(7), .COUNT(4), .ACCUM(8)) dut_b (
        .clock(clock), .reset_n(reset_n), .valid_i(vb), .data_i(data),
        .m_valid_o(mv[1]), .m_ready_i(ready), .m_last_o(ml[1]),
        .m_re_o(b_re), .m_im_o(b_im), .overflow_o(ovf[1]));

    vischain_accum #(.LENGTH(3), .WIDTH(7), .COUNT(1), .ACCUM(16)) dut_c (
        .clock(clock), .reset_n(reset_n), .valid_i(vc), .data_i(data),
        .m_valid_o(mv[2]), .m_ready_i(ready), .m_last_o(ml[2]),
        .m_re_o(c_re), .m_im_o(c_im), .overflow_o(ovf[2]));

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_pair(input int sel, input logic v, input logic l,
                            input logic [15:0] re, input logic [15:0] im, input string tag);
        chk({tag, ".valid"}, {15'd0, mv[sel]}, {15'd0, v});
        chk({tag, ".last"},  {15'd0, ml[sel]}, {15'd0, l});
        chk({tag, ".re"},    mre[sel], re);
        chk({tag, ".im"},    mim[sel], im);
    endtask

    task automatic send_word(input logic [6:0] val, input bit gap);
        if (gap) repeat ($urandom_range(0, 2)) step();
        valid_s = 1'b1;
        data    = val;
        step();
        valid_s = 1'b0;
    endtask

    task automatic send_frame(input logic [6:0] r0, input logic [6:0] i0,
                              input logic [6:0] r1, input logic [6:0] i1,
                              input logic [6:0] r2, input logic [6:0] i2, input bit gap);
        send_word(r0, gap); send_word(i0, gap);
        send_word(r1, gap); send_word(i1, gap);
        send_word(r2, gap); send_word(i2, gap);
    endtask

    task automatic drain3(input int sel, input logic [15:0] r0, input logic [15:0] r1,
                          input logic [15:0] r2, input string tag);
        chk_pair(sel, 1'b1, 1'b0, r0, r0, {tag, ".p0"}); step();
        chk_pair(sel, 1'b1, 1'b0, r1, r1, {tag, ".p1"}); step();
        chk_pair(sel, 1'b1, 1'b1, r2, r2, {tag, ".p2"}); step();
        chk({tag, ".idle"}, {15'd0, mv[sel]}, 16'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        valid_s = 1'b0;
        vsel    = 0;
        data    = '0;
        ready   = 1'b0;
        repeat (2) step();
        chk_pair(0, 1'b0, 1'b0, 16'h0, 16'h0, "reset");
        chk("reset.ovf", {15'd0, ovf[0]}, 16'd0);
        reset_n = 1'b1;
        step();

        // +1 / -1 for every unit, four frames
        ready = 1'b1;
        repeat (3) send_frame(7'h01, 7'h7F, 7'h01, 7'h7F, 7'h01, 7'h7F, 1'b0);
        send_frame(7'h01, 7'h7F, 7'h01, 7'h7F, 7'h01, 7'h7F, 1'b0);
        chk_pair(0, 1'b1, 1'b0, 16'h0004, 16'hFFFC, "pm1.p0"); step();
        chk_pair(0, 1'b1, 1'b0, 16'h0004, 16'hFFFC, "pm1.p1"); step();
        chk_pair(0, 1'b1, 1'b1, 16'h0004, 16'hFFFC, "pm1.p2"); step();
        chk("pm1.idle", {15'd0, mv[0]}, 16'd0);

        // most negative word, four frames
        repeat (4) send_frame(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 1'b0);
        drain3(0, 16'hFF00, 16'hFF00, 16'hFF00, "neg");

        // 8-bit accumulator wraps: 4 x 63 = 252 -> 0xFC
        vsel = 1;
        repeat (4) send_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b0);
        drain3(1, 16'h00FC, 16'h00FC, 16'h00FC, "wrap8");

        // gaps on the input and a stalled sink
        vsel = 0;
        repeat (3) send_frame(7'h01, 7'h01, 7'h02, 7'h02, 7'h03, 7'h03, 1'b1);
        ready = 1'b0;
        send_frame(7'h01, 7'h01, 7'h02, 7'h02, 7'h03, 7'h03, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk_pair(0, 1'b1, 1'b0, 16'd4, 16'd4, "stall.hold");
            if (i < 4) step();
        end
        ready = 1'b1;
        step();
        chk_pair(0, 1'b1, 1'b0, 16'd8, 16'd8, "stall.p1"); step();
        chk_pair(0, 1'b1, 1'b1, 16'd12, 16'd12, "stall.p2"); step();
        chk("stall.idle", {15'd0, mv[0]}, 16'd0);

        // second integration completes while the first is still undrained
        ready = 1'b0;
        repeat (4) send_frame(7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 1'b0);
        chk_pair(0, 1'b1, 1'b0, 16'd4, 16'd4, "ovf.first");
        repeat (3) send_frame(7'h02, 7'h02, 7'h02, 7'h02, 7'h02, 7'h02, 1'b0);
        chk("ovf.before", {15'd0, ovf[0]}, 16'd0);
        send_frame(7'h02, 7'h02, 7'h02, 7'h02, 7'h02, 7'h02, 1'b0);
        chk("ovf.set", {15'd0, ovf[0]}, 16'd1);
        chk_pair(0, 1'b1, 1'b0, 16'd4, 16'd4, "ovf.kept");
        ready = 1'b1;
        drain3(0, 16'd4, 16'd4, 16'd4, "ovf.drain");
        repeat (3) step();
        chk("ovf.nomore", {15'd0, mv[0]}, 16'd0);
        chk("ovf.sticky", {15'd0, ovf[0]}, 16'd1);

        // reset mid-frame, then a clean integration of +2
        send_word(7'h05, 1'b0); send_word(7'h05, 1'b0); send_word(7'h05, 1'b0);
        reset_n = 1'b0;
        #1;
        chk_pair(0, 1'b0, 1'b0, 16'h0, 16'h0, "rst.out");
        chk("rst.ovf", {15'd0, ovf[0]}, 16'd0);
        step();
        reset_n = 1'b1;
        step();
        repeat (4) send_frame(7'h02, 7'h02, 7'h02, 7'h02, 7'h02, 7'h02, 1'b0);
        drain3(0, 16'd8, 16'd8, 16'd8, "rst.drain");
        chk("rst.ovf_after", {15'd0, ovf[0]}, 16'd0);

        // COUNT=1: back-to-back frames, next frame starts on the cycle after each trigger
        vsel = 2;
        send_frame(7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 1'b0);
        for (int n = 2; n <= 3; n++) begin
            for (int w = 0; w < 6; w++) begin
                if (w < 3)
                    chk_pair(2, 1'b1, (w == 2), 16'(n - 1), 16'(n - 1), "b2b.prev");
                else if (w == 3)
                    chk("b2b.gap", {15'd0, mv[2]}, 16'd0);
                send_word(7'(n), 1'b0);
            end
        end
        drain3(2, 16'd3, 16'd3, 16'd3, "b2b.last");
        chk("b2b.ovf", {15'd0, ovf[2]}, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vischain_accum.md
Name: vischain_accum

Overview:
Downstream stage of the correlator visibility chain. It consumes the serial word stream shifted out of the end of the chain: a signed real and an imaginary word per correlator unit, for LENGTH units per frame. It integrates each unit's real and imaginary parts over COUNT frames. On completion it snapshots the sums and drains them as (re, im) pairs over a valid/ready handshake to the readout/packetiser.

Parameters:
LENGTH, 3, number of correlator units in the chain (visibility pairs per frame)
WIDTH, 7, width of each chain word, signed two's complement
COUNT, 4, frames integrated per snapshot (>=1)
ACCUM, 16, accumulator width, signed; must be >= WIDTH

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
valid_i  in  1  chain word valid
data_i  in  WIDTH  chain word, signed
m_valid_o  out  1  output pair valid
m_ready_i  in  1  downstream ready
m_last_o  out  1  marks pair for unit LENGTH-1
m_re_o  out  ACCUM  integrated real part, signed
m_im_o  out  ACCUM  integrated imaginary part, signed
overflow_o  out  1  sticky: snapshot lost because drain was still busy

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (any time, including mid-frame or mid-drain):
  - All accumulators and the snapshot bank are cleared.
  - Word counter = 0, frame counter = 0.
  - m_valid_o = 0, m_last_o = 0, m_re_o = 0, m_im_o = 0, overflow_o = 0.
  - After release, the next valid_i word is word 0 of frame 0.
- Input framing:
  - A frame is 2*LENGTH accepted words in order: u0.re, u0.im, u1.re, u1.im, ..., u(LENGTH-1).im.
  - A word is accepted on each edge with valid_i=1. Gaps (valid_i=0) are allowed anywhere; no backpressure to the chain.
  - Word counter wraps 2*LENGTH-1 -> 0 and increments the frame counter. Frame counter wraps COUNT-1 -> 0.
- Accumulation:
  - The accepted word is sign-extended to ACCUM and added to acc_re[u] or acc_im[u].
  - Arithmetic is modular two's complement: silent wrap, no saturation.
- Snapshot:
  - Trigger: the edge accepting the final word (word 2*LENGTH-1 of frame COUNT-1).
  - If the drain is idle, on that same edge:
    - The snapshot bank <= accumulators including the final word's contribution.
    - All accumulators are cleared.
    - The drain starts with index 0.
  - A word arriving on the very next cycle accumulates into the cleared bank.
- If the drain is busy at the trigger:
  - The accumulators are still cleared (integration restarts).
  - The new sums are discarded; the snapshot bank and output are untouched.
  - overflow_o <= 1 and stays 1 until reset.
- Drain (states IDLE, DRAIN):
  - IDLE -> DRAIN on an accepted snapshot; outputs for index 0 are presented after the triggering edge, so latency is 1 cycle from the final word's valid_i sample to m_valid_o=1.
  - In DRAIN, outputs are registered and held stable while m_valid_o=1 and m_ready_i=0.
  - On m_valid_o & m_ready_i, the index advances.
  - m_last_o=1 only at index LENGTH-1. A transfer at last -> IDLE, with m_valid_o=0 next cycle.
  - Throughput is 1 pair/cycle with m_ready_i held high.
- m_ready_i is ignored while m_valid_o=0.
- With COUNT=1, every frame produces a snapshot.

Test Plan:
- LENGTH=3, WIDTH=7, COUNT=4, ACCUM=16; every frame re=+1, im=-1 for all units, m_ready_i=1.
  -> 3 pairs (4, 0xFFFC), m_last_o on 3rd only; m_valid_o high 1 cycle after final word.
- All words = -64 for 4 frames -> re=im=-256 (0xFF00) for all 3 pairs. Repeat with ACCUM=8 and +63 x 4 frames -> re=252 wraps to 0xFC, read as -4.
- Random valid_i gaps, unit k words = k+1, m_ready_i low for 5 cycles after m_valid_o.
  -> pair 0 (4, 4) held stable 5 cycles; then pairs (8, 8), (12, 12) in consecutive cycles.
- m_ready_i held low through a second full integration.
  -> overflow_o=1 one cycle after the 8th frame's final word; output still shows the first snapshot; releasing ready drains the first snapshot only.
- reset_n pulsed low after 3 words of a frame, then 4 clean frames of +2.
  -> outputs immediately 0 during reset; single snapshot re=im=8 for each unit.
- Back-to-back frames, COUNT=1, m_ready_i=1, frame n words = n.
  -> each snapshot equals its own frame value; no cross-frame leakage; overflow_o stays 0.
